// File: rtl/up_dn_pkg.sv
// Shared types and constants for the up/down command generator.
package up_dn_pkg;

  // Repeat FSM states shared by the Up and Down buttons
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } state_t;

  // Width of the counter value path (Load_Val / IN)
  localparam int CNT_W = 5;

  // Parameter defaults
  localparam int DB_CYCLES_DEF = 4;
  localparam int RPT_DELAY_DEF = 16;
  localparam int RPT_RATE_DEF  = 4;

  // Button slot indices in the debouncer bank
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LOAD = 2;
  localparam int BTN_N    = 3;

  // Larger of two ints, used to size the shared repeat timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a level debouncer for one raw button.
module btn_debounce
  import up_dn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the raw button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive disagreeing cycles;
  // the count never exceeds DB_CYCLES because reaching it commits the level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (sync2_reg == level_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg >= CW'(DB_CYCLES)) begin
      level_reg <= sync2_reg;
      cnt_reg   <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/up_dn_cmd_gen.sv
// Turns three bouncing buttons into one-cycle Load/Up/Down commands with
// auto-repeat on Up/Down and High/Low suppression from the counter.
module up_dn_cmd_gen
  import up_dn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int RPT_DELAY = RPT_DELAY_DEF,
  parameter int RPT_RATE  = RPT_RATE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Btn_Up,
  input  logic             Btn_Down,
  input  logic             Btn_Load,
  input  logic [CNT_W-1:0] Load_Val,
  input  logic             High,
  input  logic             Low,
  output logic [CNT_W-1:0] IN,
  output logic             Load,
  output logic             Up,
  output logic             Down
);

  localparam int TMAX = max_int(RPT_DELAY, RPT_RATE);
  localparam int TW   = $clog2(TMAX + 1);

  logic [BTN_N-1:0] btn_raw;
  logic [BTN_N-1:0] db_lvl;
  logic [BTN_N-1:0] db_prev_reg;
  logic [BTN_N-1:0] rise;

  state_t           state_reg, state_next;
  logic [TW-1:0]    timer_reg, timer_next, timer_sat;
  logic             dir_reg, dir_next;      // 0: Up held, 1: Down held
  logic             fire_up, fire_dn;
  logic             load_fire;

  logic [CNT_W-1:0] in_reg;
  logic             load_reg, up_reg, dn_reg;

  assign btn_raw = {Btn_Load, Btn_Down, Btn_Up};

  for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_raw[gi]),
      .level (db_lvl[gi])
    );
  end

  // Remember last debounced levels for rise detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_prev_reg <= '0;
    else        db_prev_reg <= db_lvl;
  end

  assign rise = db_lvl & ~db_prev_reg;

  // Shared FSM conditions
  logic both_hi, start_up, start_dn, held_ok, delay_hit, rate_hit;
  assign both_hi   = db_lvl[BTN_UP] & db_lvl[BTN_DOWN];
  assign start_up  = rise[BTN_UP]   & ~db_lvl[BTN_DOWN];
  assign start_dn  = rise[BTN_DOWN] & ~db_lvl[BTN_UP];
  assign held_ok   = (dir_reg ? db_lvl[BTN_DOWN] : db_lvl[BTN_UP]) & ~both_hi;
  assign delay_hit = (timer_reg >= TW'(RPT_DELAY - 1));
  assign rate_hit  = (timer_reg >= TW'(RPT_RATE - 1));
  assign timer_sat = (timer_reg == TW'(TMAX)) ? timer_reg : timer_reg + TW'(1);
  assign load_fire = rise[BTN_LOAD];

  // FSM state, timer and held-direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      dir_reg   <= dir_next;
    end
  end

  // Next-state: timer restarts on every issued pulse so cadence is pulse-relative
  always_comb begin
    state_next = state_reg;
    timer_next = timer_sat;
    dir_next   = dir_reg;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (start_up) begin
          state_next = WAIT;
          dir_next   = 1'b0;
        end else if (start_dn) begin
          state_next = WAIT;
          dir_next   = 1'b1;
        end
      end
      WAIT: begin
        if (!held_ok) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (delay_hit) begin
          state_next = RPT;
          timer_next = '0;
        end
      end
      RPT: begin
        if (!held_ok) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (rate_hit) begin
          timer_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Output decode: which direction the FSM wants to pulse this cycle
  always_comb begin
    fire_up = 1'b0;
    fire_dn = 1'b0;
    case (state_reg)
      IDLE: begin
        fire_up = start_up;
        fire_dn = start_dn;
      end
      WAIT: begin
        fire_up = held_ok & delay_hit & ~dir_reg;
        fire_dn = held_ok & delay_hit &  dir_reg;
      end
      RPT: begin
        fire_up = held_ok & rate_hit & ~dir_reg;
        fire_dn = held_ok & rate_hit &  dir_reg;
      end
      default: begin
        fire_up = 1'b0;
        fire_dn = 1'b0;
      end
    endcase
  end

  // Registered commands: Load wins, and High/Low mask only the pulse, not the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_reg   <= '0;
      load_reg <= 1'b0;
      up_reg   <= 1'b0;
      dn_reg   <= 1'b0;
    end else begin
      load_reg <= load_fire;
      up_reg   <= fire_up & ~High & ~load_fire;
      dn_reg   <= fire_dn & ~Low  & ~load_fire;
      if (load_fire) in_reg <= Load_Val;
    end
  end

  assign IN   = in_reg;
  assign Load = load_reg;
  assign Up   = up_reg;
  assign Down = dn_reg;

endmodule

// File: tb/tb_up_dn_cmd_gen.sv
// Bench for up_dn_cmd_gen: table of single-button holds plus hand-built
// bounce, collision, feedback and reset sequences, checked via a scoreboard.
module tb_up_dn_cmd_gen;
  import up_dn_pkg::*;

  localparam int DB  = 4;
  localparam int RD  = 16;
  localparam int RR  = 4;
  localparam int LAT = 2 + DB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Btn_Up = 1'b0, Btn_Down = 1'b0, Btn_Load = 1'b0;
  logic [4:0] Load_Val = '0;
  logic       High = 1'b0, Low = 1'b0;
  logic [4:0] IN;
  logic       Load, Up, Down;

  up_dn_cmd_gen #(.DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_RATE(RR)) dut (
    .clk(clk), .rst_n(rst_n), .Btn_Up(Btn_Up), .Btn_Down(Btn_Down),
    .Btn_Load(Btn_Load), .Load_Val(Load_Val), .High(High), .Low(Low),
    .IN(IN), .Load(Load), .Up(Up), .Down(Down)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       ld;
    logic       up;
    logic       dn;
    logic [4:0] inv;
  } ev_t;

  typedef struct {
    int         btn;
    int         hold;
    logic       high;
    logic       low;
    logic [4:0] val;
  } vec_t;

  ev_t        sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [4:0] model_in = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Insert an expected pulse keeping the scoreboard ordered by cycle
  task automatic push(input int c, input logic ld, input logic up, input logic dn,
                      input logic [4:0] v);
    ev_t e;
    int  i;
    e.cyc = c; e.ld = ld; e.up = up; e.dn = dn; e.inv = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  // Expected pulses for one button raw-high on edges base..base+h-1
  task automatic model_hold(input int base, input int btn, input int h,
                            input logic sup, input logic [4:0] val);
    int e;
    if (h < DB + 1) return;
    if (btn == 2) begin
      model_in = val;
      push(base + LAT, 1'b1, 1'b0, 1'b0, model_in);
    end else if (!sup) begin
      e = LAT;
      while (e <= h + 2 + DB) begin
        push(base + e, 1'b0, btn == 0, btn == 1, model_in);
        e = (e == LAT) ? LAT + RD : e + RR;
      end
    end
  endtask

  task automatic set_btn(input int btn, input logic v);
    case (btn)
      0:       Btn_Up   = v;
      1:       Btn_Down = v;
      default: Btn_Load = v;
    endcase
  endtask

  // Called at posedge+2; the raw level is sampled high on the next h edges
  task automatic press(input int btn, input int h);
    set_btn(btn, 1'b1);
    repeat (h) @(posedge clk);
    #2;
    set_btn(btn, 1'b0);
  endtask

  // Compare every cycle: expected event or all-quiet
  task automatic monitor_loop();
    ev_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event: expected at cycle %0d ld=%0b up=%0b dn=%0b, now %0d",
                 e.cyc, e.ld, e.up, e.dn, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("event_cmds", {Load, Up, Down}, {e.ld, e.up, e.dn});
        chk("event_in", IN, e.inv);
        $display("event cycle=%0d Load=%0b Up=%0b Down=%0b IN=%0d", cyc, Load, Up, Down, IN);
      end else begin
        chk("quiet_cmds", {Load, Up, Down}, 0);
      end
    end
  endtask

  vec_t vecs[13];
  int   base;

  initial begin
    vecs[0]  = '{0, 10, 1'b0, 1'b0, 5'd0};   // clean Up press
    vecs[1]  = '{1, 10, 1'b0, 1'b0, 5'd0};   // clean Down press
    vecs[2]  = '{0,  4, 1'b0, 1'b0, 5'd0};   // too short to debounce
    vecs[3]  = '{0,  5, 1'b0, 1'b0, 5'd0};   // shortest accepted press
    vecs[4]  = '{2, 10, 1'b0, 1'b0, 5'd13};  // Load 13
    vecs[5]  = '{0, 41, 1'b0, 1'b0, 5'd0};   // Up auto-repeat, 8 pulses
    vecs[6]  = '{1, 30, 1'b0, 1'b0, 5'd0};   // Down auto-repeat
    vecs[7]  = '{0, 30, 1'b1, 1'b0, 5'd0};   // Up masked by High
    vecs[8]  = '{1, 30, 1'b0, 1'b1, 5'd0};   // Down masked by Low
    vecs[9]  = '{0, 30, 1'b0, 1'b1, 5'd0};   // Low does not affect Up
    vecs[10] = '{1, 30, 1'b1, 1'b0, 5'd0};   // High does not affect Down
    vecs[11] = '{2,  8, 1'b0, 1'b0, 5'd22};  // Load 22
    vecs[12] = '{0, 20, 1'b0, 1'b0, 5'd0};   // Up after reload

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset_load", Load, 0);
    chk("reset_up",   Up,   0);
    chk("reset_down", Down, 0);
    chk("reset_in",   IN,   0);
    rst_n = 1'b1;
    fork
      monitor_loop();
    join_none
    repeat (2) @(posedge clk);
    #2;

    // Table-driven single-button holds
    for (int i = 0; i < 13; i++) begin
      High = vecs[i].high;
      Low = vecs[i].low;
      Load_Val = vecs[i].val;
      base = cyc + 1;
      model_hold(base, vecs[i].btn,  vecs[i].hold,
                 (vecs[i].btn == 0) ? vecs[i].high : vecs[i].low, vecs[i].val);
      press(vecs[i].btn, vecs[i].hold);
      repeat (30) @(posedge clk);
      #2;
    end
    High = 1'b0;
    Low = 1'b0;

    // Bounce: toggle every 2 cycles for 20 cycles, then stable high
    base = cyc + 1;
    push(base + 20 + LAT, 1'b0, 1'b0, 1'b1, model_in);
    for (int i = 0; i < 20; i++) begin
      Btn_Down = ((i % 4) < 2);
      @(posedge clk);
      #2;
    end
    press(1, 10);
    repeat (30) @(posedge clk);
    #2;

    // Both buttons together: nothing
    fork
      press(0, 30);
      press(1, 30);
    join
    repeat (30) @(posedge clk);
    #2;

    // Down pressed while Up is in WAIT: FSM drops to IDLE, no further pulses
    base = cyc + 1;
    push(base + LAT, 1'b0, 1'b1, 1'b0, model_in);
    fork
      press(0, 40);
      begin repeat (10) @(posedge clk); #2; press(1, 40); end
    join
    repeat (30) @(posedge clk);
    #2;

    // High held through the first pulses, dropped after t0+22
    High = 1'b1;
    base = cyc + 1;
    push(base + 31, 1'b0, 1'b1, 1'b0, model_in);
    push(base + 35, 1'b0, 1'b1, 1'b0, model_in);
    push(base + 39, 1'b0, 1'b1, 1'b0, model_in);
    fork
      press(0, 35);
      begin repeat (30) @(posedge clk); #2; High = 1'b0; end
    join
    repeat (30) @(posedge clk);
    #2;

    // Load collides with the t0+24 Up pulse; Up cadence continues unchanged
    Load_Val = 5'd19;
    base = cyc + 1;
    push(base + 7,  1'b0, 1'b1, 1'b0, model_in);
    push(base + 23, 1'b0, 1'b1, 1'b0, model_in);
    push(base + 27, 1'b0, 1'b1, 1'b0, model_in);
    model_in = 5'd19;
    push(base + 31, 1'b1, 1'b0, 1'b0, model_in);
    for (int e = 35; e <= 51; e += 4) push(base + e, 1'b0, 1'b1, 1'b0, model_in);
    fork
      press(0, 45);
      begin repeat (24) @(posedge clk); #2; press(2, 6); end
    join
    repeat (30) @(posedge clk);
    #2;

    // Reset mid-RPT right after a pulse, button still held across release
    base = cyc + 1;
    push(base + 7,  1'b0, 1'b1, 1'b0, model_in);
    push(base + 23, 1'b0, 1'b1, 1'b0, model_in);
    push(base + 27, 1'b0, 1'b1, 1'b0, model_in);
    Btn_Up = 1'b1;
    repeat (28) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_up",   Up,   0);
    chk("async_reset_load", Load, 0);
    chk("async_reset_down", Down, 0);
    chk("async_reset_in",   IN,   0);
    model_in = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = cyc + 1;
    push(base + LAT, 1'b0, 1'b1, 1'b0, model_in);
    repeat (10) @(posedge clk);
    #2;
    Btn_Up = 1'b0;
    repeat (40) @(posedge clk);
    #2;

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
